// File: rtl/alu_seq_ctrl.sv
// Initiator-side sequencer for a 12-bit combinational ALU: accepts load/op commands,
// repeats an op cmd_count+1 times with accumulator feedback. Optional checker: ALU_SEQ_CTRL_CHECK_EN.
module alu_seq_ctrl #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_fun,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] acc,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem;
  logic             take;

  assign take  = cmd_valid & cmd_ready;
  assign alu_a = acc;
  assign zero  = (acc == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = cmd_load ? DONE : DRIVE;
      DRIVE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = (rem == '0) ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) & ~reset;
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  // Datapath: acc only ever takes the load value or alu_y verbatim.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      alu_b   <= '0;
      alu_fun <= '0;
      rem     <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          if (cmd_load) acc <= cmd_operand;
          else begin
            alu_b   <= cmd_operand;
            alu_fun <= cmd_fun;
            rem     <= cmd_count;
          end
        end
        CAPTURE: begin
          acc <= alu_y;
          if (rem != '0) rem <= rem - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_CTRL_CHECK_EN
  logic [WIDTH-1:0] expect_y;

  always_comb begin
    expect_y = '0;
    case (alu_fun)
      3'd0: expect_y = acc & alu_b;
      3'd1: expect_y = acc | alu_b;
      3'd2: expect_y = acc + alu_b;
      3'd3: expect_y = '0;
      3'd4: expect_y = acc & ~alu_b;
      3'd5: expect_y = acc | ~alu_b;
      3'd6: expect_y = acc - alu_b;
      3'd7: expect_y = (acc < alu_b) ? '1 : '0;
      default: expect_y = '0;
    endcase
  end

  // Sticky until reset; the result is still captured even when it disagrees.
  always_ff @(posedge clk) begin
    if (reset)                                       err <= 1'b0;
    else if (state == CAPTURE && alu_y != expect_y)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: bench-side ALU, per-cycle schedule model, literal spot checks.
module tb_alu_seq_ctrl;
  localparam int W  = 12;
  localparam int CW = 4;
`ifdef ALU_SEQ_CTRL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_load = 1'b0;
  logic [2:0]    cmd_fun = '0;
  logic [W-1:0]  cmd_operand = '0;
  logic [CW-1:0] cmd_count = '0;
  logic          cmd_ready, zero, busy, done, err;
  logic [W-1:0]  alu_a, alu_b, alu_y, acc;
  logic [2:0]    alu_fun;
  logic          fault = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_fun(cmd_fun), .cmd_operand(cmd_operand), .cmd_count(cmd_count),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_y(alu_y),
    .acc(acc), .zero(zero), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] f);
    case (f)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return '0;
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return a - b;
      default: return (a < b) ? '1 : '0;
    endcase
  endfunction

  // External ALU; fault flips bit 0 of its result.
  assign alu_y = alu_f(alu_a, alu_b, alu_fun) ^ {{(W-1){1'b0}}, fault};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: on each accepted command, precompute what every following cycle must show.
  typedef struct {
    logic [W-1:0] acc;
    logic         busy;
    logic         done;
    logic         err;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] m_acc = '0, m_b = '0;
  logic [2:0]   m_fun = '0;
  logic         m_err = 1'b0;
  bit           started = 1'b0;

  always @(posedge clk) begin
    bit idle_now;
    logic [W-1:0] cur;
    exp_t dummy;
    idle_now = (q.size() == 0);
    if (reset) begin
      q.delete();
      m_acc = '0; m_b = '0; m_fun = '0; m_err = 1'b0;
      started = 1'b1;
    end else begin
      if (!idle_now) dummy = q.pop_front();
      if (idle_now && cmd_valid) begin
        if (cmd_load) begin
          m_acc = cmd_operand;
          q.push_back('{m_acc, 1'b1, 1'b1, m_err});
        end else begin
          m_b = cmd_operand;
          m_fun = cmd_fun;
          cur = m_acc;
          for (int i = 0; i <= int'(cmd_count); i++) begin
            q.push_back('{cur, 1'b1, 1'b0, m_err});
            q.push_back('{cur, 1'b1, 1'b0, m_err});
            if (CHK && fault) m_err = 1'b1;
            cur = alu_f(cur, m_b, m_fun) ^ {{(W-1){1'b0}}, fault};
          end
          q.push_back('{cur, 1'b1, 1'b1, m_err});
          m_acc = cur;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      e = (q.size() != 0) ? q[0] : '{m_acc, 1'b0, 1'b0, m_err};
      chk("acc", acc, e.acc);
      chk("alu_a", alu_a, e.acc);
      chk("zero", zero, e.acc == '0);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("err", err, e.err);
      chk("cmd_ready", cmd_ready, (q.size() == 0) && !reset);
      chk("alu_b", alu_b, m_b);
      chk("alu_fun", alu_fun, m_fun);
    end
  end

  // Edges counted from the call until cmd_ready was seen high before an edge.
  task automatic wait_hs(output int k);
    bit r;
    k = 0;
    do begin
      @(negedge clk); r = cmd_ready;
      @(posedge clk); #1; k++;
    end while (!r && k < 200);
    if (!r) chk("handshake_timeout", 0, 1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!done && lat < 100);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic issue(input bit ld, input logic [2:0] f, input logic [W-1:0] op,
                       input logic [CW-1:0] c, output int lat);
    int k;
    cmd_load = ld; cmd_fun = f; cmd_operand = op; cmd_count = c; cmd_valid = 1'b1;
    wait_hs(k);
    cmd_valid = 1'b0;
    wait_done(lat);
  endtask

  initial begin
    int lat, k, done_at;
    bit r;
    // 1: reset held with a pending command
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = 12'h3AA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_acc", acc, 12'h000);
    chk("rst_zero", zero, 1);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1; reset = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    // 2: load
    issue(1'b1, 3'd0, 12'h123, 4'd0, lat);
    chk("load_lat", lat, 1);
    chk("load_acc", acc, 12'h123);
    chk("load_fun", alu_fun, 3'd0);

    // 3: four adds, with a second command held while busy
    cmd_load = 1'b0; cmd_fun = 3'd2; cmd_operand = 12'h010; cmd_count = 4'd3; cmd_valid = 1'b1;
    wait_hs(k);
    cmd_load = 1'b1; cmd_operand = 12'h0AB;
    k = 0; done_at = 0;
    do begin
      @(negedge clk); r = cmd_ready;
      if (done) begin
        done_at = k + 1;
        chk("add4_acc", acc, 12'h163);
      end
      @(posedge clk); #1; k++;
    end while (!r && k < 50);
    chk("add4_lat", done_at, 9);
    chk("held_accept", k, 10);
    cmd_valid = 1'b0;
    wait_done(lat);
    chk("held_load_acc", acc, 12'h0AB);

    // 4: wrap-around
    issue(1'b1, 3'd0, 12'hFFF, 4'd0, lat);
    issue(1'b0, 3'd2, 12'h002, 4'd0, lat);
    chk("wrap_add_lat", lat, 3);
    chk("wrap_add", acc, 12'h001);
    issue(1'b0, 3'd6, 12'h002, 4'd0, lat);
    chk("wrap_sub", acc, 12'hFFF);

    // 5: compare / zero functions
    issue(1'b1, 3'd0, 12'h005, 4'd0, lat);
    issue(1'b0, 3'd7, 12'h006, 4'd0, lat);
    chk("lt_true", acc, 12'hFFF);
    issue(1'b0, 3'd7, 12'h001, 4'd0, lat);
    chk("lt_false", acc, 12'h000);
    chk("lt_zero", zero, 1);
    issue(1'b0, 3'd3, 12'h5A5, 4'd0, lat);
    chk("fun3", acc, 12'h000);

    // max repeat count
    issue(1'b0, 3'd2, 12'h001, 4'd15, lat);
    chk("max_cnt_lat", lat, 33);
    chk("max_cnt_acc", acc, 12'h010);

    // 6: reset mid-command
    cmd_load = 1'b0; cmd_fun = 3'd2; cmd_operand = 12'h001; cmd_count = 4'd5; cmd_valid = 1'b1;
    wait_hs(k);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("abort_acc", acc, 12'h000);
    chk("abort_busy", busy, 0);
    repeat (3) @(negedge clk);

    // corrupted ALU result
    fault = 1'b1;
    issue(1'b0, 3'd2, 12'h001, 4'd1, lat);
    chk("fault_lat", lat, 5);
    chk("fault_err", err, CHK);
    fault = 1'b0;
    issue(1'b1, 3'd0, 12'h007, 4'd0, lat);
    chk("err_sticky", err, CHK);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("err_cleared", err, 0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
